// File: rtl/mips_bus_arbiter_if.sv
// Avalon-MM master bundle between mips_bus_arbiter (master) and the memory fabric (slave).
interface mips_bus_arbiter_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon master between fetch (I) and load/store (D); 2 cycles minimum per access, strobes held while waitrequest.
// Define MIPS_BUS_ARB_ROUND_ROBIN_EN to replace fixed D-over-I priority with alternating grants on contention.
module mips_bus_arbiter #(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_req,
  input  logic [31:0]        i_addr,
  output logic [31:0]        i_rdata,
  output logic               i_done,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [31:0]        d_addr,
  input  logic [31:0]        d_wdata,
  input  logic [3:0]         d_be,
  output logic [31:0]        d_rdata,
  output logic               d_done,
  output logic               busy,
  output logic               bus_error,
  mips_bus_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER_I = 2'd1, XFER_D = 2'd2} state_t;

  localparam logic [TIMEOUT_W:0] TIMEOUT_LIM = (TIMEOUT_W + 1)'(TIMEOUT);

  state_t               state, state_nxt;
  logic [31:0]          bus_addr, bus_addr_nxt;
  logic [31:0]          bus_wdata, bus_wdata_nxt;
  logic [3:0]           bus_be, bus_be_nxt;
  logic                 bus_rd, bus_rd_nxt;
  logic                 bus_wr, bus_wr_nxt;
  logic [31:0]          i_rdata_nxt, d_rdata_nxt;
  logic                 i_done_nxt, d_done_nxt, busy_nxt, bus_error_nxt;
  logic [TIMEOUT_W-1:0] stall_cnt, stall_cnt_nxt;
  logic [TIMEOUT_W:0]   stall_cnt_inc;
  logic                 i_eff, d_eff, grant_i, grant_d;
  logic                 strobe, complete, stalled, timeout_hit;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

  // A port's request is ignored during its own done cycle, since the requester has not yet seen the pulse
  assign i_eff = i_req && !i_done;
  assign d_eff = d_req && !d_done;

`ifdef MIPS_BUS_ARB_ROUND_ROBIN_EN
  logic last_grant;  // 1 = D granted last

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      last_grant <= 1'b0;
    else if (state == IDLE && (grant_i || grant_d))
      last_grant <= grant_d;
  end

  assign grant_d = d_eff && (!i_eff || !last_grant);
`else
  assign grant_d = d_eff;
`endif
  assign grant_i = i_eff && !grant_d;

  assign strobe        = bus_rd || bus_wr;
  assign complete      = strobe && !bus.waitrequest;
  assign stalled       = strobe && bus.waitrequest;
  assign stall_cnt_inc = {1'b0, stall_cnt} + {{TIMEOUT_W{1'b0}}, 1'b1};
  assign timeout_hit   = (TIMEOUT != 0) && stalled && (stall_cnt_inc == TIMEOUT_LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
      busy      <= 1'b0;
      bus_error <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      bus_addr  <= bus_addr_nxt;
      bus_wdata <= bus_wdata_nxt;
      bus_be    <= bus_be_nxt;
      bus_rd    <= bus_rd_nxt;
      bus_wr    <= bus_wr_nxt;
      i_rdata   <= i_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
      i_done    <= i_done_nxt;
      d_done    <= d_done_nxt;
      busy      <= busy_nxt;
      bus_error <= bus_error_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (grant_d)
          state_nxt = XFER_D;
        else if (grant_i)
          state_nxt = XFER_I;
      end
      XFER_I, XFER_D: begin
        if (complete || timeout_hit)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus_addr_nxt  = bus_addr;
    bus_wdata_nxt = bus_wdata;
    bus_be_nxt    = bus_be;
    bus_rd_nxt    = bus_rd;
    bus_wr_nxt    = bus_wr;
    i_rdata_nxt   = i_rdata;
    d_rdata_nxt   = d_rdata;
    i_done_nxt    = 1'b0;
    d_done_nxt    = 1'b0;
    bus_error_nxt = bus_error;
    stall_cnt_nxt = stall_cnt;
    busy_nxt      = (state_nxt != IDLE);
    unique case (state)
      IDLE: begin
        stall_cnt_nxt = '0;
        if (grant_d) begin
          bus_addr_nxt = {d_addr[31:2], 2'b00};
          bus_rd_nxt   = !d_we;
          bus_wr_nxt   = d_we;
          bus_be_nxt   = d_be;
          if (d_we)
            bus_wdata_nxt = d_wdata;
        end else if (grant_i) begin
          bus_addr_nxt = {i_addr[31:2], 2'b00};
          bus_rd_nxt   = 1'b1;
          bus_wr_nxt   = 1'b0;
          bus_be_nxt   = 4'hF;
        end
      end
      XFER_I, XFER_D: begin
        if (complete || timeout_hit) begin
          bus_rd_nxt = 1'b0;
          bus_wr_nxt = 1'b0;
          if (state == XFER_I) begin
            i_done_nxt  = 1'b1;
            i_rdata_nxt = timeout_hit ? 32'h0 : bus.readdata;
          end else begin
            d_done_nxt = 1'b1;
            if (timeout_hit)
              d_rdata_nxt = 32'h0;
            else if (bus_rd)
              d_rdata_nxt = bus.readdata;
          end
          if (timeout_hit)
            bus_error_nxt = 1'b1;
        end else if (stalled) begin
          stall_cnt_nxt = stall_cnt_inc[TIMEOUT_W-1:0];
        end
      end
      default: begin
        bus_rd_nxt = 1'b0;
        bus_wr_nxt = 1'b0;
      end
    endcase
  end

  assign bus.address    = bus_addr;
  assign bus.read       = bus_rd;
  assign bus.write      = bus_wr;
  assign bus.writedata  = bus_wdata;
  assign bus.byteenable = bus_be;

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Sequences the single Avalon memory-mapped master port of the multi-cycle MIPS core.
- Shares that port between two requesters: the instruction-fetch port (I) and the load/store data port (D).
- Owns all Avalon handshake timing: waitrequest stalls, readdata capture and bus-hang timeout.
- Sits between the CPU control/datapath and the top-level Avalon pins.

Parameters:
- TIMEOUT, 255, waitrequest-stall cycles before an access is aborted; 0 disables the timeout.
- TIMEOUT_W, 8, width of the stall counter; must satisfy TIMEOUT < 2^TIMEOUT_W.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request; level, held until i_done.
- i_addr  in  32  fetch byte address.
- i_rdata  out  32  fetched word, valid while i_done=1.
- i_done  out  1  one-cycle completion pulse for the fetch port.
- d_req  in  1  data request; level, held until d_done.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_be  in  4  store/load byte enables.
- d_rdata  out  32  load word, valid while d_done=1.
- d_done  out  1  one-cycle completion pulse for the data port.
- busy  out  1  high in any state other than IDLE.
- bus_error  out  1  sticky flag, set on timeout abort.
- address  out  32  Avalon address.
- read  out  1  Avalon read strobe.
- write  out  1  Avalon write strobe.
- waitrequest  in  1  Avalon stall.
- writedata  out  32  Avalon write data.
- byteenable  out  4  Avalon byte enables.
- readdata  in  32  Avalon read data.

Behaviour:
- States: IDLE, XFER_I, XFER_D. Every output is registered.
- Reset (async, reset=0): state=IDLE, read=write=0, address=0, writedata=0, byteenable=0, i_done=d_done=0, i_rdata=d_rdata=0, bus_error=0, busy=0, stall counter=0.
  - Reset mid-transfer drops read/write immediately; no done pulse is issued.
- IDLE:
  - Effective request = req AND NOT own done. A requester's still-high req during its done cycle is therefore ignored.
  - Arbitration: D wins when both requests are active (fixed priority).
  - Grant edge: load address={addr[31:2],2'b00}.
    - Fetch: read=1, byteenable=4'b1111.
    - Data load: read=1. Data store: write=1.
    - Data accesses use byteenable=d_be; writedata=d_wdata for stores.
  - Clear the stall counter.
- First bus cycle latency: req seen high at edge N → strobe asserted from edge N.
- XFER_x:
  - address, strobes, writedata and byteenable are held stable while waitrequest=1.
  - Each stalled cycle increments the stall counter.
  - Completion = (read|write)=1 and waitrequest=0 at an edge. On that edge:
    - drop strobes;
    - capture readdata into i_rdata or d_rdata (loads/fetches only; unchanged on stores);
    - pulse the matching done for exactly one cycle;
    - go to IDLE.
  - Timeout (TIMEOUT≠0): counter reaches TIMEOUT with waitrequest still 1.
    - Drop strobes; set bus_error=1 (sticky until reset).
    - Pulse the matching done; rdata=32'h0000_0000.
    - Go to IDLE.
- Back-to-back accesses: minimum 2 cycles per access (grant + completion), plus one IDLE cycle between accesses.
- d_be=4'b0000: bus cycle still issued with byteenable=0; completes normally.
- Only one outstanding access at a time; requests arriving during XFER wait in IDLE order.

Optional Feature:
- Macro: MIPS_BUS_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_grant register resets to I.
  - On simultaneous effective requests, the port not granted last wins; after reset D is granted first.
  - last_grant updates on every grant edge.
- Undefined: fixed D-over-I priority; no last_grant register exists.

Test Plan:
- Fetch, no stall: i_req=1, i_addr=32'h0000_0103, waitrequest=0, readdata=32'h2402_000A → address=32'h0000_0100, byteenable=4'hF, read high one cycle; next cycle i_done=1, i_rdata=32'h2402_000A.
- Store with stall: d_req=1, d_we=1, d_addr=32'h1000_0008, d_wdata=32'hDEAD_BEEF, d_be=4'b0011, waitrequest high 3 cycles → write, address, writedata and byteenable stable for 4 cycles; d_done pulses once; d_rdata unchanged.
- Contention: i_req and d_req rise on the same edge.
  - Fixed priority: D served first, then I.
  - With MIPS_BUS_ARB_ROUND_ROBIN_EN: D first, then I; repeat contention → D, I alternation.
- Timeout: TIMEOUT=4, load with waitrequest stuck at 1 → read drops after 4 stall cycles; d_done=1; d_rdata=0; bus_error stays 1 until reset.
- Reset mid-read: reset=0 during XFER_I → read=0 asynchronously, no i_done; after release, a new i_req completes normally.
- Done-cycle masking: requester holds i_req one extra cycle after i_done → exactly one additional fetch is issued, not two.
